// File: rtl/avalon_mm_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin Avalon-MM arbiter.
package avalon_mm_rr_arbiter_pkg;

  localparam int DEF_NUM_HOSTS   = 2;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_MAX_PENDING = 4;

  // Command class seen on an Avalon-MM link; used by benches/monitors.
  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2
  } avmm_cmd_e;

  // Bits needed to carry a host index; never narrower than one bit.
  function automatic int host_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/avalon_mm_rr_arbiter_if.sv
// N-lane Avalon-MM bundle. readdata is shared across lanes (broadcast),
// everything else is per lane. The agent side uses N=1.
interface avalon_mm_rr_arbiter_if #(
  parameter int N      = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [N-1:0][ADDR_W-1:0] address;
  logic [N-1:0][BE_W-1:0]   byteenable;
  logic [N-1:0]             read;
  logic [N-1:0]             write;
  logic [N-1:0][DATA_W-1:0] writedata;
  logic [DATA_W-1:0]        readdata;
  logic [N-1:0]             waitrequest;
  logic [N-1:0]             readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  readdata, waitrequest, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output readdata, waitrequest, readdatavalid
  );
endinterface

// File: rtl/avalon_mm_rr_arbiter_id_fifo.sv
// In-order FIFO of host IDs for reads accepted by the agent but not yet returned.
module id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // full/empty come straight from the registered count, so a pop never frees
  // a slot for a push in the same cycle.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/avalon_mm_rr_arbiter.sv
// N-host to 1-agent Avalon-MM round-robin arbiter with pipelined reads.
// The command path is combinational; the winning ID of each accepted read is
// queued so the in-order response can be steered back to its issuer.
module avalon_mm_rr_arbiter
  import avalon_mm_rr_arbiter_pkg::*;
#(
  parameter int NUM_HOSTS   = DEF_NUM_HOSTS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MAX_PENDING = DEF_MAX_PENDING
) (
  input  logic                    clk,
  input  logic                    rst_n,
  avalon_mm_rr_arbiter_if.slave   h,
  avalon_mm_rr_arbiter_if.master  a,
  output logic                    err_unexpected_rdv
);
  localparam int ID_W  = host_id_w(NUM_HOSTS);
  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  logic [NUM_HOSTS-1:0] req;
  logic [ID_W-1:0]      rr_ptr, grant_q, scan_id, gnt, head;
  logic                 locked, found, gvld, stall, issued;
  logic                 push, pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]     pending;

  assign req = h.read | h.write;

  // Round-robin scan: first requester at or after rr_ptr, wrapping.
  always_comb begin
    scan_id = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_HOSTS; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_HOSTS) idx = idx - NUM_HOSTS;
      if (!found && req[idx]) begin
        found   = 1'b1;
        scan_id = ID_W'(idx);
      end
    end
  end

  // A stalled agent pins the grant so the command stays stable.
  assign gnt  = locked ? grant_q : scan_id;
  assign gvld = locked | found;

  // Only reads back-pressure on a full ID queue; writes have no response.
  assign stall = gvld & h.read[gnt] & (pending == CNT_W'(MAX_PENDING));

  assign a.address[0]    = h.address[gnt];
  assign a.byteenable[0] = h.byteenable[gnt];
  assign a.writedata[0]  = h.writedata[gnt];
  assign a.read[0]       = rst_n & gvld & ~stall & h.read[gnt];
  assign a.write[0]      = rst_n & gvld & ~stall & h.write[gnt];

  assign issued = a.read[0] | a.write[0];
  assign push   = a.read[0] & ~a.waitrequest[0] & ~fifo_full;
  assign pop    = a.readdatavalid[0] & ~fifo_empty;

  assign h.readdata = a.readdata;

  // Per-host stall and response strobe; reset forces the idle/stalled view.
  always_comb begin
    h.waitrequest   = '1;
    h.readdatavalid = '0;
    for (int i = 0; i < NUM_HOSTS; i++) begin
      h.waitrequest[i]   = ~(rst_n & gvld & (gnt == ID_W'(i)) & ~stall & ~a.waitrequest[0]);
      h.readdatavalid[i] = rst_n & pop & (head == ID_W'(i));
    end
  end

  // Grant lock, round-robin pointer and sticky unexpected-response flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr             <= '0;
      locked             <= 1'b0;
      grant_q            <= '0;
      err_unexpected_rdv <= 1'b0;
    end else begin
      if (issued) begin
        if (a.waitrequest[0]) begin
          locked  <= 1'b1;
          grant_q <= gnt;
        end else begin
          locked <= 1'b0;
          rr_ptr <= (gnt == ID_W'(NUM_HOSTS - 1)) ? '0 : gnt + ID_W'(1);
        end
      end
      if (a.readdatavalid[0] && fifo_empty) err_unexpected_rdv <= 1'b1;
    end
  end

  id_fifo #(.WIDTH(ID_W), .DEPTH(MAX_PENDING)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (gnt),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head),
    .count (pending)
  );
endmodule
